load_writeback_unit: RTL and testbench
======================================

// Module: load_writeback_unit
// PURPOSE
//   Writeback stage feeding the 32x32 register file write port (en / rd index / data_in).
//   Accepts one retiring instruction at a time and selects the result: ALU, PC+4, IMM or a load.
//   Loads issue a handshaked data-memory read, then byte/half-align and sign/zero-extend the word.
//   Drives a one-cycle write-enable pulse; writes to x0 are suppressed here as well.
// PARAMETERS
//   XLEN          32   datapath width
//   TIMEOUT_CYCLES 64  max cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN)
// PORTS
//   clk         in   1     system clock, rising edge
//   rst         in   1     asynchronous, active-low reset
//   wb_valid    in   1     upstream has an instruction to retire
//   wb_ready    out  1     unit can accept (high only in IDLE)
//   wb_rd       in   5     destination register index
//   wb_sel      in   2     result select: 00 ALU, 01 LOAD, 10 PC4, 11 IMM
//   wb_funct3   in   3     load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   alu_result  in   32    ALU result; effective address when wb_sel=LOAD
//   pc_plus4    in   32    PC+4 for JAL/JALR
//   imm         in   32    immediate for LUI
//   mem_req     out  1     data-memory read request
//   mem_addr    out  32    word-aligned read address ({addr[31:2],2'b00})
//   mem_ack     in   1     read data valid this cycle
//   mem_rdata   in   32    read word
//   rf_en       out  1     register-file write enable (one-cycle pulse)
//   rf_rd       out  5     register-file write index
//   rf_data     out  32    register-file write data
//   wb_err      out  1     one-cycle pulse: misaligned load (or timeout, if enabled)
// BEHAVIOUR
//   - Reset (rst=0, any state): state=IDLE; wb_ready=1; mem_req, rf_en, wb_err=0; rf_rd=0, rf_data=0, mem_addr=0.
//     Any in-flight instruction is dropped; no write occurs. Release is synchronous to the next clk edge.
//   - States: IDLE, MEM_WAIT, WRITE. Accept = wb_valid & wb_ready (IDLE only).
//   - IDLE, accept, wb_sel!=LOAD -> WRITE. Result, rd captured. rf_en=1 the next cycle (latency 1).
//   - IDLE, accept, LOAD, aligned -> MEM_WAIT. Capture addr[1:0], funct3, rd. mem_req=1 from the next cycle.
//     Aligned means: LW addr[1:0]=00; LH/LHU addr[0]=0; LB/LBU any.
//   - IDLE, accept, LOAD misaligned or unsupported funct3 -> stay IDLE. wb_err=1 the next cycle; no write.
//   - MEM_WAIT: mem_req and mem_addr held stable until mem_ack.
//     On mem_ack, extend mem_rdata and register it -> WRITE. mem_req drops the cycle after the ack.
//     mem_ack while not in MEM_WAIT is ignored.
//   - Extend rules:
//       LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1]; LW whole word.
//       B/H sign-extend from the top bit of the field; BU/HU zero-extend.
//   - WRITE: rf_en=1 for exactly one cycle. If rf_rd==0, rf_en=0 but the cycle is still spent. -> IDLE.
//     wb_ready=0 in MEM_WAIT and WRITE, so back-to-back throughput is one instruction per 2 cycles (non-load).
//   - rf_rd/rf_data hold their last value when rf_en=0.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined:
//     An 8-bit counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
//     At TIMEOUT_CYCLES: mem_req drops, wb_err pulses, -> IDLE, no write.
//     An ack arriving in the same cycle as the timeout wins (normal path).
//   MEM_TIMEOUT_EN undefined: no counter; MEM_WAIT waits indefinitely; wb_err only flags misalignment.
// STRUCTURE
//   rv32i_pkg:
//     WB_SEL_{ALU,LOAD,PC4,IMM} codes
//     F3_{LB,LH,LW,LBU,LHU} codes
//     state encoding localparams IDLE/MEM_WAIT/WRITE
//   Sub-module load_extender (combinational): funct3, addr[1:0], word in -> 32-bit extended value out.
//   FSM, capture registers and timeout counter stay in load_writeback_unit.
// TESTING
//   1 ALU op: wb_sel=00, rd=5, alu_result=0x1234_5678 -> next cycle rf_en=1, rf_rd=5, rf_data=0x1234_5678; wb_ready=0 that cycle.
//   2 LB sign: addr=0x1003, mem_rdata=0x80FF_FF7F, ack after 3 cycles -> rf_data=0xFFFF_FF80, mem_addr=0x1000, rf_en one cycle after ack.
//   3 LHU vs LH: addr=0x2002, mem_rdata=0x8001_0000 -> LHU writes 0x0000_8001; LH writes 0xFFFF_8001.
//   4 Misaligned LW: addr=0x3001 -> mem_req never asserts, wb_err pulses 1 cycle, rf_en stays 0.
//   5 rd=x0 with ALU op: rf_en stays 0, wb_ready returns after 2 cycles. Reset during MEM_WAIT -> mem_req=0 immediately, no write after release.
//   6 (MEM_TIMEOUT_EN) no ack for 64 cycles -> wb_err pulse, IDLE, no write; ack exactly on cycle 64 -> normal write.

Source files
------------

// File: rtl/load_writeback_unit_pkg.sv
// Shared codes and types for the load/writeback stage: result selects, load funct3
// codes, FSM state encoding and the load-alignment helper.
package rv32i_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned F3_W   = 3;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] WRITE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_MEM_WAIT = MEM_WAIT,
        ST_WRITE    = WRITE
    } wb_state_e;

    // Context of an outstanding load, held across MEM_WAIT
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [F3_W-1:0]   funct3;
        logic [1:0]        offset;
    } load_ctx_t;

    // True when funct3 is a supported load and the byte offset is naturally aligned
    function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~off[0];
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Bundle of the retire, data-memory read and register-file write signals of the
// writeback stage. The unit sits on the slave side.
interface load_writeback_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [1:0]      wb_sel;
    logic [2:0]      wb_funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    logic            rf_en;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;
    logic            wb_err;

    modport master (
        output wb_valid, wb_rd, wb_sel, wb_funct3, alu_result, pc_plus4, imm,
        output mem_ack, mem_rdata,
        input  wb_ready, mem_req, mem_addr, rf_en, rf_rd, rf_data, wb_err
    );

    modport slave (
        input  wb_valid, wb_rd, wb_sel, wb_funct3, alu_result, pc_plus4, imm,
        input  mem_ack, mem_rdata,
        output wb_ready, mem_req, mem_addr, rf_en, rf_rd, rf_data, wb_err
    );

endinterface

// File: rtl/load_writeback_unit_load_extender.sv
// Combinational load formatter: picks the byte/half/word addressed by the low
// address bits and sign- or zero-extends it according to funct3.
module load_extender
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = 8'h00;
        case (offset)
            2'd0:    byte_c = word[7:0];
            2'd1:    byte_c = word[15:8];
            2'd2:    byte_c = word[23:16];
            default: byte_c = word[31:24];
        endcase
        half_c = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value_c = word;
        case (funct3)
            F3_LB:   value_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            F3_LBU:  value_c = {{(XLEN-8){1'b0}}, byte_c};
            F3_LH:   value_c = {{(XLEN-16){half_c[15]}}, half_c};
            F3_LHU:  value_c = {{(XLEN-16){1'b0}}, half_c};
            default: value_c = word;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Writeback stage: selects ALU/PC+4/IMM/load result and drives a one-cycle RF write.
// Optional MEM_TIMEOUT_EN aborts a load whose mem_ack does not arrive in TIMEOUT_CYCLES.
module load_writeback_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    load_writeback_unit_if.slave bus
);

    localparam int unsigned CNT_W = 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the %0d-bit wait counter", CNT_W);
    end

    wb_state_e         state_q, state_d;
    load_ctx_t         ctx_q, ctx_d;
    logic              ready_q, ready_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              rf_en_q, rf_en_d;
    logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_data_q, rf_data_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic [XLEN-1:0]   result_c;
    logic [XLEN-1:0]   load_val_c;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_c;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign accept_c = bus.wb_valid & ready_q;

    load_extender #(.XLEN(XLEN)) u_ext (
        .funct3  (ctx_q.funct3),
        .offset  (ctx_q.offset),
        .word    (bus.mem_rdata),
        .value_c (load_val_c)
    );

    // Non-load result select
    always_comb begin
        result_c = bus.alu_result;
        case (bus.wb_sel)
            WB_SEL_PC4: result_c = bus.pc_plus4;
            WB_SEL_IMM: result_c = bus.imm;
            default:    result_c = bus.alu_result;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        mem_addr_d = mem_addr_q;
        rf_en_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        err_d      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (bus.wb_sel == WB_SEL_LOAD) begin
                        if (load_ok(bus.wb_funct3, bus.alu_result[1:0])) begin
                            ctx_d.rd     = bus.wb_rd;
                            ctx_d.funct3 = bus.wb_funct3;
                            ctx_d.offset = bus.alu_result[1:0];
                            mem_addr_d   = {bus.alu_result[XLEN-1:2], 2'b00};
                            state_d      = ST_MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
                            cnt_d        = '0;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_WRITE;
                        if (bus.wb_rd != '0) begin
                            rf_en_d   = 1'b1;
                            rf_rd_d   = bus.wb_rd;
                            rf_data_d = result_c;
                        end
                    end
                end
            end
            ST_MEM_WAIT: begin
                // An ack in the timeout cycle still completes the load
                if (bus.mem_ack) begin
                    state_d = ST_WRITE;
                    if (ctx_q.rd != '0) begin
                        rf_en_d   = 1'b1;
                        rf_rd_d   = ctx_q.rd;
                        rf_data_d = load_val_c;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ready_d   = (state_d == ST_IDLE);
        mem_req_d = (state_d == ST_MEM_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctx_q      <= '0;
            ready_q    <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            ready_q    <= ready_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            err_q      <= err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    assign bus.wb_ready = ready_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rf_en    = rf_en_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_data  = rf_data_q;
    assign bus.wb_err   = err_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit; register-file writes and error pulses
// are checked by a monitor against queues filled as stimulus is issued.
module tb_load_writeback_unit;
    import rv32i_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_writeback_unit_if #(.XLEN(32)) bus ();

    load_writeback_unit #(.XLEN(32), .TIMEOUT_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t exp_q[$];
    int  err_exp = 0;
    int  errors  = 0;
    int  checks  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write or error pulse must match an expectation
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rf_en === 1'b1) begin
                wr_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual rd=%0d data=%h required=no write",
                             bus.rf_rd, bus.rf_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rf_rd !== e.rd || bus.rf_data !== e.data) begin
                        errors++;
                        $display("FAIL rf_write actual rd=%0d data=%h required rd=%0d data=%h",
                                 bus.rf_rd, bus.rf_data, e.rd, e.data);
                    end
                end
            end
            if (bus.wb_err === 1'b1) begin
                checks++;
                if (err_exp == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb_err actual=1 required=0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] immv);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.wb_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("wb_ready_wait", bus.wb_ready, 32'h1);
        bus.wb_sel     = sel;
        bus.wb_rd      = rd;
        bus.wb_funct3  = f3;
        bus.alu_result = alu;
        bus.pc_plus4   = pc4;
        bus.imm        = immv;
        bus.wb_valid   = 1'b1;
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
    endtask

    task automatic mem_serve(input logic [31:0] addr, input logic [31:0] data,
                             input int delay, input logic wr);
        int   n;
        logic stable;
        n      = 0;
        stable = 1'b1;
        @(negedge clk);
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_seen", 32'(bus.mem_req), 32'h1);
        chk("mem_addr", bus.mem_addr, addr);
        repeat (delay) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr) stable = 1'b0;
        end
        chk("mem_req_held", 32'(stable), 32'h1);
        bus.mem_rdata = data;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h5A5A_5A5A;
        chk("rf_en_after_ack", 32'(bus.rf_en), 32'(wr));
        chk("mem_req_drop", 32'(bus.mem_req), 32'h0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] result);
        expect_wr(rd, result);
        issue(WB_SEL_LOAD, rd, f3, addr, 32'h0, 32'h0);
        mem_serve({addr[31:2], 2'b00}, data, 2, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_sel     = '0;
        bus.wb_funct3  = '0;
        bus.alu_result = '0;
        bus.pc_plus4   = '0;
        bus.imm        = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;

        repeat (3) @(negedge clk);
        chk("rst_wb_ready", 32'(bus.wb_ready), 32'h1);
        chk("rst_mem_req",  32'(bus.mem_req),  32'h0);
        chk("rst_rf_en",    32'(bus.rf_en),    32'h0);
        chk("rst_wb_err",   32'(bus.wb_err),   32'h0);
        chk("rst_rf_rd",    32'(bus.rf_rd),    32'h0);
        chk("rst_rf_data",  bus.rf_data,       32'h0);
        chk("rst_mem_addr", bus.mem_addr,      32'h0);
        rst = 1'b1;

        // ALU op, latency one, ready low during the write cycle
        expect_wr(5'd5, 32'h1234_5678);
        issue(WB_SEL_ALU, 5'd5, 3'b000, 32'h1234_5678, 32'hDEAD_0000, 32'hBEEF_0000);
        @(negedge clk);
        chk("alu_rf_en",    32'(bus.rf_en),    32'h1);
        chk("alu_wb_ready", 32'(bus.wb_ready), 32'h0);

        // PC+4 and IMM back to back
        expect_wr(5'd1, 32'h0000_0100);
        issue(WB_SEL_PC4, 5'd1, 3'b000, 32'h1111_1111, 32'h0000_0100, 32'h2222_2222);
        expect_wr(5'd31, 32'hABCD_E000);
        issue(WB_SEL_IMM, 5'd31, 3'b000, 32'h3333_3333, 32'h4444_4444, 32'hABCD_E000);

        // LB sign extension, ack three cycles after request
        expect_wr(5'd7, 32'hFFFF_FF80);
        issue(WB_SEL_LOAD, 5'd7, F3_LB, 32'h0000_1003, 32'h0, 32'h0);
        mem_serve(32'h0000_1000, 32'h80FF_FF7F, 3, 1'b1);

        load(5'd8,  F3_LHU, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        load(5'd9,  F3_LH,  32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        load(5'd10, F3_LW,  32'h0000_2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load(5'd11, F3_LBU, 32'h0000_2001, 32'h0000_A500, 32'h0000_00A5);
        load(5'd12, F3_LH,  32'h0000_2000, 32'hFFFF_7FFF, 32'h0000_7FFF);
        load(5'd13, F3_LB,  32'h0000_2000, 32'h1234_5681, 32'hFFFF_FF81);

        // Misaligned / unsupported loads: error pulse, no request, no write
        err_exp++;
        issue(WB_SEL_LOAD, 5'd14, F3_LW, 32'h0000_3001, 32'h0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("misaligned_no_req", 32'(bus.mem_req), 32'h0);
        end
        chk("misaligned_ready", 32'(bus.wb_ready), 32'h1);
        err_exp++;
        issue(WB_SEL_LOAD, 5'd15, F3_LHU, 32'h0000_3003, 32'h0, 32'h0);
        err_exp++;
        issue(WB_SEL_LOAD, 5'd16, 3'b011, 32'h0000_3000, 32'h0, 32'h0);
        @(negedge clk);
        chk("bad_f3_no_req", 32'(bus.mem_req), 32'h0);

        // Write to x0: cycle spent, no write
        issue(WB_SEL_ALU, 5'd0, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        @(negedge clk);
        chk("x0_busy",  32'(bus.wb_ready), 32'h0);
        @(negedge clk);
        chk("x0_ready", 32'(bus.wb_ready), 32'h1);

        // Reset during MEM_WAIT drops the load
        issue(WB_SEL_LOAD, 5'd17, F3_LW, 32'h0000_4000, 32'h0, 32'h0);
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_async_mem_req",  32'(bus.mem_req),  32'h0);
        chk("rst_async_wb_ready", 32'(bus.wb_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        chk("post_rst_no_req", 32'(bus.mem_req), 32'h0);
        repeat (3) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            err_exp++;
            issue(WB_SEL_LOAD, 5'd18, F3_LW, 32'h0000_5000, 32'h0, 32'h0);
            @(negedge clk);
            n = 0;
            while (bus.mem_req === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_req_cycles", 32'(n), 32'd64);
            chk("timeout_ready", 32'(bus.wb_ready), 32'h1);
        end
        expect_wr(5'd19, 32'h0BAD_F00D);
        issue(WB_SEL_LOAD, 5'd19, F3_LW, 32'h0000_5004, 32'h0, 32'h0);
        mem_serve(32'h0000_5004, 32'h0BAD_F00D, 63, 1'b1);
`else
        // Without the timeout a slow ack still completes normally
        expect_wr(5'd18, 32'h0BAD_F00D);
        issue(WB_SEL_LOAD, 5'd18, F3_LW, 32'h0000_5000, 32'h0, 32'h0);
        mem_serve(32'h0000_5000, 32'h0BAD_F00D, 80, 1'b1);
`endif

        repeat (5) @(negedge clk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'h0);
        chk("errs_outstanding",   32'(err_exp),      32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
